// File: rtl/scs8hd_clkdlyline_prog_if.sv
// Sample/config bundle for the programmable clock delay line.
// Master drives samples and delay requests. Slave is the delay line, which
// returns the delayed samples and its handshake/status signals.
interface scs8hd_clkdlyline_prog_if #(
  parameter int unsigned WIDTH    = 1,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned DEPTH    = 8
) ();
  localparam int unsigned DW = CHANNELS * WIDTH;
  localparam int unsigned AW = $clog2(DEPTH);

  logic [DW-1:0] a;
  logic          a_vld;
  logic [DW-1:0] x;
  logic          x_vld;
  logic          cfg_vld;
  logic [AW-1:0] cfg_dly;
  logic          cfg_rdy;
  logic [AW-1:0] dly_cur;
  logic          busy;

  modport master (
    output a, a_vld, cfg_vld, cfg_dly,
    input  x, x_vld, cfg_rdy, dly_cur, busy
  );

  modport slave (
    input  a, a_vld, cfg_vld, cfg_dly,
    output x, x_vld, cfg_rdy, dly_cur, busy
  );
endinterface

// File: rtl/scs8hd_clkdlyline_prog.sv
// Programmable multi-lane delay line.
// A DEPTH-stage register chain carries {data, valid} for all lanes and
// shifts every cycle. One shared tap selects the delay. After a delay change,
// a settle machine masks x_vld until the selected tap holds only samples
// captured after the change.
module scs8hd_clkdlyline_prog #(
  parameter int unsigned WIDTH    = 1,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned DLY_RST  = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  scs8hd_clkdlyline_prog_if.slave     bus
);
  localparam int unsigned DW = CHANNELS * WIDTH;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] MAX_DLY = AW'(DEPTH - 32'd1);
  localparam logic [AW-1:0] RST_DLY = AW'(DLY_RST);

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_SETTLE = 1'b1
  } state_e;

  // Clamp a requested setting to the last real stage. This only matters
  // when DEPTH is not a power of two.
  function automatic logic [AW-1:0] sat_dly(input logic [AW-1:0] v);
    if (32'(v) > (DEPTH - 32'd1)) begin
      sat_dly = MAX_DLY;
    end else begin
      sat_dly = v;
    end
  endfunction

  logic [DW-1:0]    r_data [DEPTH];
  logic [DEPTH-1:0] r_vld;
  state_e           r_state;
  logic [AW-1:0]    r_cnt;
  logic [AW-1:0]    r_dly_cur;

  state_e           w_state_nxt;
  logic [AW-1:0]    w_cnt_nxt;
  logic [AW-1:0]    w_dly_nxt;
  logic             w_cfg_rdy;
  logic             w_accept;

  // cfg_rdy depends on reset combinationally so that no handshake can
  // appear to complete on an edge that is resetting the block.
  assign w_cfg_rdy = (r_state == ST_RUN) && !reset;
  assign w_accept  = bus.cfg_vld && w_cfg_rdy;

  // Sample chain: shifts every cycle, invalid samples ride along as bubbles.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= {DW{1'b0}};
      end
      r_vld <= {DEPTH{1'b0}};
    end else begin
      r_data[0] <= bus.a;
      for (int i = 1; i < DEPTH; i++) begin
        r_data[i] <= r_data[i-1];
      end
      r_vld <= {r_vld[DEPTH-2:0], bus.a_vld};
    end
  end

  // Control state register: FSM state, settle counter and active tap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_RUN;
      r_cnt     <= {AW{1'b0}};
      r_dly_cur <= RST_DLY;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_dly_cur <= w_dly_nxt;
    end
  end

  // Next-state logic. SETTLE lasts sat(cfg_dly)+1 cycles so that the new
  // tap has been refilled entirely with samples captured after the accept.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dly_nxt   = r_dly_cur;
    case (r_state)
      ST_RUN: begin
        if (w_accept) begin
          w_state_nxt = ST_SETTLE;
          w_cnt_nxt   = sat_dly(bus.cfg_dly);
          w_dly_nxt   = sat_dly(bus.cfg_dly);
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_SETTLE: begin
        if (r_cnt == {AW{1'b0}}) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_cnt_nxt = r_cnt - AW'(1);
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_cnt_nxt   = {AW{1'b0}};
      end
    endcase
  end

  // Output logic: tap mux of registered state, valid masked while settling.
  always_comb begin
    bus.x       = r_data[r_dly_cur];
    bus.x_vld   = 1'b0;
    bus.busy    = 1'b0;
    bus.cfg_rdy = w_cfg_rdy;
    bus.dly_cur = r_dly_cur;
    case (r_state)
      ST_RUN: begin
        bus.x_vld = r_vld[r_dly_cur];
        bus.busy  = 1'b0;
      end
      ST_SETTLE: begin
        bus.x_vld = 1'b0;
        bus.busy  = 1'b1;
      end
      default: begin
        bus.x_vld = 1'b0;
        bus.busy  = 1'b0;
      end
    endcase
  end
endmodule

// File: tb/tb_scs8hd_clkdlyline_prog.sv
// Directed self-checking bench for scs8hd_clkdlyline_prog (defaults:
// WIDTH=1, CHANNELS=2, DEPTH=8, DLY_RST=3). Inputs change on the falling
// edge; outputs are checked on the falling edge after each rising edge.
module tb_scs8hd_clkdlyline_prog;
  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  scs8hd_clkdlyline_prog_if #(.WIDTH(1), .CHANNELS(2), .DEPTH(8)) u_if ();

  scs8hd_clkdlyline_prog #(
    .WIDTH(1), .CHANNELS(2), .DEPTH(8), .DLY_RST(3)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  logic       vld_pat [4];
  logic [1:0] dat_pat [4];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    clk       = 1'b0;
    reset     = 1'b1;
    u_if.a       = 2'b00;
    u_if.a_vld   = 1'b0;
    u_if.cfg_vld = 1'b1;
    u_if.cfg_dly = 3'd6;

    // Reset held two cycles; a cfg request during reset must not be taken.
    tick();
    chk_val("rst_x",       32'(u_if.x),       32'd0);
    chk_val("rst_x_vld",   32'(u_if.x_vld),   32'd0);
    chk_val("rst_cfg_rdy", 32'(u_if.cfg_rdy), 32'd0);
    chk_val("rst_dly_cur", 32'(u_if.dly_cur), 32'd3);
    chk_val("rst_busy",    32'(u_if.busy),    32'd0);
    tick();
    chk_val("rst_cfg_rdy2", 32'(u_if.cfg_rdy), 32'd0);
    chk_val("rst_dly_cur2", 32'(u_if.dly_cur), 32'd3);
    reset        = 1'b0;
    u_if.cfg_vld = 1'b0;
    #1;
    chk_val("rel_cfg_rdy", 32'(u_if.cfg_rdy), 32'd1);

    // Default latency: one sample, delay 3 -> visible after 4th edge only.
    u_if.a     = 2'b01;
    u_if.a_vld = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk_val($sformatf("lat3_vld_k%0d", k), 32'(u_if.x_vld), (k == 4) ? 32'd1 : 32'd0);
      chk_val($sformatf("lat3_x_k%0d", k),   32'(u_if.x),     (k == 4) ? 32'd1 : 32'd0);
      if (k == 1) begin
        u_if.a     = 2'b00;
        u_if.a_vld = 1'b0;
      end
    end

    // Reprogram to 5: SETTLE covers 6 cycles, fresh sample lands after 6 edges.
    u_if.cfg_vld = 1'b1;
    u_if.cfg_dly = 3'd5;
    for (int k = 0; k <= 7; k++) begin
      tick();
      chk_val($sformatf("d5_busy_k%0d", k),  32'(u_if.busy),    (k <= 5) ? 32'd1 : 32'd0);
      chk_val($sformatf("d5_rdy_k%0d", k),   32'(u_if.cfg_rdy), (k >= 6) ? 32'd1 : 32'd0);
      chk_val($sformatf("d5_vld_k%0d", k),   32'(u_if.x_vld),   (k == 6) ? 32'd1 : 32'd0);
      chk_val($sformatf("d5_dly_k%0d", k),   32'(u_if.dly_cur), 32'd5);
      if (k == 6) begin
        chk_val("d5_x", 32'(u_if.x), 32'd2);
      end
      if (k == 0) begin
        u_if.cfg_vld = 1'b0;
        u_if.a       = 2'b10;
        u_if.a_vld   = 1'b1;
      end else if (k == 1) begin
        u_if.a     = 2'b00;
        u_if.a_vld = 1'b0;
      end
    end

    // Back-to-back: request 3, then hold a request for 0 through SETTLE.
    u_if.cfg_vld = 1'b1;
    u_if.cfg_dly = 3'd3;
    for (int k = 0; k <= 7; k++) begin
      tick();
      chk_val($sformatf("b2b_busy_k%0d", k),
              32'(u_if.busy), ((k <= 3) || (k == 5)) ? 32'd1 : 32'd0);
      chk_val($sformatf("b2b_dly_k%0d", k),
              32'(u_if.dly_cur), (k <= 4) ? 32'd3 : 32'd0);
      chk_val($sformatf("b2b_vld_k%0d", k),
              32'(u_if.x_vld), (k == 6) ? 32'd1 : 32'd0);
      if (k == 0) begin
        u_if.cfg_dly = 3'd0;
      end else if (k == 4) begin
        chk_val("b2b_rdy_run", 32'(u_if.cfg_rdy), 32'd1);
      end else if (k == 5) begin
        u_if.cfg_vld = 1'b0;
        u_if.a       = 2'b11;
        u_if.a_vld   = 1'b1;
      end else if (k == 6) begin
        chk_val("b2b_x", 32'(u_if.x), 32'd3);
        u_if.a     = 2'b00;
        u_if.a_vld = 1'b0;
      end
    end

    // Bubbles at delay 2: pattern 1,0,1,1 emerges 3 edges after it is driven.
    vld_pat[0] = 1'b1; dat_pat[0] = 2'b01;
    vld_pat[1] = 1'b0; dat_pat[1] = 2'b00;
    vld_pat[2] = 1'b1; dat_pat[2] = 2'b10;
    vld_pat[3] = 1'b1; dat_pat[3] = 2'b11;
    u_if.cfg_vld = 1'b1;
    u_if.cfg_dly = 3'd2;
    for (int k = 0; k <= 8; k++) begin
      tick();
      chk_val($sformatf("bub_busy_k%0d", k), 32'(u_if.busy), (k <= 2) ? 32'd1 : 32'd0);
      if ((k >= 3) && (k <= 6)) begin
        chk_val($sformatf("bub_vld_k%0d", k), 32'(u_if.x_vld), 32'(vld_pat[k-3]));
        chk_val($sformatf("bub_x_k%0d", k),   32'(u_if.x),     32'(dat_pat[k-3]));
      end else begin
        chk_val($sformatf("bub_vld_k%0d", k), 32'(u_if.x_vld), 32'd0);
      end
      if (k == 0) begin
        u_if.cfg_vld = 1'b0;
      end
      if (k <= 3) begin
        u_if.a     = dat_pat[k];
        u_if.a_vld = vld_pat[k];
      end else begin
        u_if.a     = 2'b00;
        u_if.a_vld = 1'b0;
      end
    end

    // Reset on the second cycle of a settle to 7, with samples in flight.
    u_if.cfg_vld = 1'b1;
    u_if.cfg_dly = 3'd7;
    u_if.a       = 2'b11;
    u_if.a_vld   = 1'b1;
    tick();
    chk_val("mid_busy0", 32'(u_if.busy), 32'd1);
    u_if.cfg_vld = 1'b0;
    tick();
    chk_val("mid_busy1", 32'(u_if.busy),    32'd1);
    chk_val("mid_dly1",  32'(u_if.dly_cur), 32'd7);
    reset = 1'b1;
    tick();
    chk_val("mid_rst_rdy",  32'(u_if.cfg_rdy), 32'd0);
    chk_val("mid_rst_busy", 32'(u_if.busy),    32'd0);
    chk_val("mid_rst_dly",  32'(u_if.dly_cur), 32'd3);
    chk_val("mid_rst_vld",  32'(u_if.x_vld),   32'd0);
    chk_val("mid_rst_x",    32'(u_if.x),       32'd0);
    reset      = 1'b0;
    u_if.a     = 2'b00;
    u_if.a_vld = 1'b0;
    #1;
    chk_val("mid_rel_rdy", 32'(u_if.cfg_rdy), 32'd1);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk_val($sformatf("mid_post_vld_k%0d", k), 32'(u_if.x_vld), 32'd0);
      chk_val($sformatf("mid_post_x_k%0d", k),   32'(u_if.x),     32'd0);
      chk_val($sformatf("mid_post_busy_k%0d", k), 32'(u_if.busy), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
